// File: rtl/ysyx_22040383_mem_access.sv
// MEM-stage data-memory access unit: one load or store per instruction over a
// valid/ready request + response bus, stalling the pipeline until it completes.
module ysyx_22040383_mem_access #(
  parameter int XLEN = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            mempr_mem_valid,
  input  logic            mempr_mem_is_write_dmem,
  input  logic [1:0]      mempr_mem_wb_select,
  input  logic [7:0]      mempr_mem_write_width,
  input  logic            mempr_mem_load_unsigned,
  input  logic [XLEN-1:0] mempr_mem_rs2_data,
  input  logic [XLEN-1:0] mempr_mem_alu_res,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [7:0]      dmem_req_wmask,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            mem_stall,
  output logic            mem_done,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wen;
    logic [7:0]      wmask;
    logic [XLEN-1:0] wdata;
    logic [7:0]      size;
    logic            uns;
    logic [2:0]      off;
    logic            fault;
  } acc_t;

  state_t          state_q, state_d;
  acc_t            acc_q, acc_d;
  logic [XLEN-1:0] rdata_q;
  logic            access;
  logic            size_ok;
  logic [2:0]      align_mask;
  logic            bad;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] fmt;

  assign access = mempr_mem_valid &
                  (mempr_mem_is_write_dmem | (mempr_mem_wb_select == 2'b01));

  // Size legality and the low address bits that must be zero for that size.
  always_comb begin
    size_ok    = 1'b1;
    align_mask = 3'b000;
    case (mempr_mem_write_width)
      8'h01:   align_mask = 3'b000;
      8'h03:   align_mask = 3'b001;
      8'h0F:   align_mask = 3'b011;
      8'hFF:   align_mask = 3'b111;
      default: size_ok    = 1'b0;
    endcase
  end

  assign bad = ~size_ok | (|(mempr_mem_alu_res[2:0] & align_mask));

  always_comb begin
    acc_d       = '0;
    acc_d.addr  = {mempr_mem_alu_res[XLEN-1:3], 3'b000};
    acc_d.wen   = mempr_mem_is_write_dmem;
    acc_d.wmask = mempr_mem_write_width << mempr_mem_alu_res[2:0];
    acc_d.wdata = mempr_mem_rs2_data << {mempr_mem_alu_res[2:0], 3'b000};
    acc_d.size  = mempr_mem_write_width;
    acc_d.uns   = mempr_mem_load_unsigned;
    acc_d.off   = mempr_mem_alu_res[2:0];
    acc_d.fault = bad;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (access) state_d = bad ? DONE : REQ;
      REQ:  if (dmem_req_ready) state_d = WAIT;
      WAIT: if (dmem_rsp_valid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      // EX/MEM is frozen by the stall, but only the IDLE snapshot is trusted.
      if (state_q == IDLE && access) acc_q <= acc_d;
      if (state_q == WAIT && dmem_rsp_valid) rdata_q <= dmem_rsp_rdata;
    end
  end

  assign shifted = rdata_q >> {acc_q.off, 3'b000};

  always_comb begin
    fmt = shifted;
    case (acc_q.size)
      8'h01:   fmt = {{(XLEN-8){~acc_q.uns & shifted[7]}},   shifted[7:0]};
      8'h03:   fmt = {{(XLEN-16){~acc_q.uns & shifted[15]}}, shifted[15:0]};
      8'h0F:   fmt = {{(XLEN-32){~acc_q.uns & shifted[31]}}, shifted[31:0]};
      default: fmt = shifted;
    endcase
  end

  assign dmem_req_valid = (state_q == REQ);
  assign dmem_req_addr  = acc_q.addr;
  assign dmem_req_wen   = acc_q.wen;
  assign dmem_req_wmask = acc_q.wmask;
  assign dmem_req_wdata = acc_q.wdata;

  assign mem_stall = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == WAIT);
  assign mem_done  = (state_q == DONE);
  assign mem_fault = (state_q == DONE) & acc_q.fault;
  assign mem_rdata = (state_q == DONE && !acc_q.wen && !acc_q.fault) ? fmt : '0;

endmodule
